ex_mem_flags_stage: RTL and testbench
=====================================

Name: ex_mem_flags_stage

Overview:
EX/MEM pipeline register and architectural NZCV flag register, directly downstream of the 64-bit ALU.
- Captures the ALU result, the ALU flags and the EX control bits into the MEM stage.
- Commits NZCV on flag-setting instructions (ADDS/SUBS).
- Evaluates B.cond conditions for the ID stage, bypassing the flags of a flag-setting instruction still in EX.
- Honours pipeline stall and flush from the hazard unit.

Parameters:
WIDTH, 64, datapath width of result and store data
REG_BITS, 5, register-specifier width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ex_valid  input  1  EX holds a real instruction
ex_result  input  WIDTH  ALU result
ex_negative  input  1  ALU negative flag
ex_zero  input  1  ALU zero flag
ex_overflow  input  1  ALU overflow flag
ex_carry_out  input  1  ALU carry-out flag
ex_set_flags  input  1  instruction writes NZCV
ex_store_data  input  WIDTH  forwarded Rt value for STUR
ex_rd  input  REG_BITS  destination register
ex_reg_write  input  1  writes register file
ex_mem_read  input  1  load
ex_mem_write  input  1  store
stall  input  1  hold the stage
flush  input  1  kill the EX instruction
id_cond  input  4  B.cond condition field from ID
mem_valid  output  1  MEM holds a real instruction
mem_result  output  WIDTH  registered ALU result (memory address or writeback value)
mem_store_data  output  WIDTH  registered store data
mem_rd  output  REG_BITS  registered destination
mem_reg_write  output  1  registered; forced 0 when bubble
mem_mem_read  output  1  registered; forced 0 when bubble
mem_mem_write  output  1  registered; forced 0 when bubble
flags_nzcv  output  4  architectural flags {N,Z,C,V}
cond_taken  output  1  combinational: id_cond satisfied by the effective flags

Behaviour:
- Reset: all registered outputs are 0, including mem_valid and flags_nzcv = 4'b0000. Reset overrides stall and flush in the same cycle.
- Priority each edge: reset > flush > stall > normal.
- Normal (no stall, no flush):
  - All mem_* registers load their ex_* counterparts; mem_valid <= ex_valid.
  - Control bits load as (ex_x & ex_valid), so a bubble never carries write enables.
- Stall (no flush): every mem_* register and flags_nzcv hold their values.
- Flush:
  - mem_valid, mem_reg_write, mem_mem_read and mem_mem_write <= 0.
  - Payload registers may load or hold; the bench checks no payload while mem_valid = 0.
  - flags_nzcv holds.
- Flag commit:
  - flags_nzcv <= {ex_negative, ex_zero, ex_carry_out, ex_overflow} on an edge where ex_valid & ex_set_flags & !stall & !flush.
  - Otherwise flags_nzcv holds.
  - Latency: 1 cycle from EX to flags_nzcv.
- Effective flags for cond_taken:
  - The ex_* flag inputs when ex_valid & ex_set_flags & !flush. This bypass applies during stall too.
  - Otherwise flags_nzcv.
  - cond_taken has zero-cycle latency: purely combinational from id_cond, ex_* and the flags register.
- Condition codes (LEGv8):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE !(!Z&(N==V)); E and F always (cond_taken = 1).
- Back-to-back flag setters: each commits in order. Bypass always reflects the younger (EX) instruction.
- ALU flags are used as delivered, with no recomputation. carry_out and overflow are meaningful only for ADDS/SUBS; decode must not assert ex_set_flags for other ops.
- Reset mid-stall or mid-flush: the stage returns to reset values on the next edge. No pending state survives.

Decomposition:
- Package pipe_pkg holds:
  - the cond_e enum (4-bit EQ..AL codes above);
  - the nzcv_t packed struct {n, z, c, v};
  - index localparams for the flag bit positions.
- One sub-module, cond_evaluator: nzcv_t and cond_e in, taken out; purely combinational. It is reused by the branch unit.
- The flag register and the pipeline registers live in ex_mem_flags_stage itself.

Test Plan:
- Reset: assert reset with all inputs 1 -> next edge all outputs 0 and flags_nzcv = 0000; cond_taken = 1 for id_cond = E, 0 for EQ.
- SUBS 5-5 (ex_zero = 1, ex_carry_out = 1, ex_set_flags = 1, ex_valid = 1), id_cond = EQ -> cond_taken = 1 in the same cycle via bypass; next edge flags_nzcv = 0110, mem_result = 0.
- ADD with ex_set_flags = 0, ex_result = 64'h1234, rd = 3, reg_write = 1 -> next edge mem_result = 64'h1234, mem_rd = 3, mem_reg_write = 1; flags unchanged.
- Stall for 2 cycles holding a SUBS producing N = 1 -> mem_* and flags_nzcv frozen both cycles; cond_taken(MI) = 1 throughout; commit on the first unstalled edge.
- Flush together with stall on a flag-setting store -> next edge mem_valid = 0, mem_mem_write = 0, flags unchanged; bypass disabled (cond_taken reflects the register).
- Signed compare: flags_nzcv = 1000 (N = 1, V = 0) -> GE = 0, LT = 1, GT = 0, LE = 1; flags_nzcv = 1001 -> GE = 1, GT = 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: LEGv8 branch condition codes and the NZCV flag layout.
package pipe_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic nzcv_t make_nzcv(input logic n, input logic z, input logic c,
                                      input logic v);
    nzcv_t f;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/ex_mem_flags_stage_if.sv
// EX-side inputs, MEM-side outputs and the branch-condition query of the EX/MEM stage.
interface ex_mem_flags_stage_if #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
);
  logic                ex_valid;
  logic [WIDTH-1:0]    ex_result;
  logic                ex_negative;
  logic                ex_zero;
  logic                ex_overflow;
  logic                ex_carry_out;
  logic                ex_set_flags;
  logic [WIDTH-1:0]    ex_store_data;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                stall;
  logic                flush;
  logic [3:0]          id_cond;

  logic                mem_valid;
  logic [WIDTH-1:0]    mem_result;
  logic [WIDTH-1:0]    mem_store_data;
  logic [REG_BITS-1:0] mem_rd;
  logic                mem_reg_write;
  logic                mem_mem_read;
  logic                mem_mem_write;
  logic [3:0]          flags_nzcv;
  logic                cond_taken;

  modport master (
    output ex_valid, ex_result, ex_negative, ex_zero, ex_overflow, ex_carry_out,
           ex_set_flags, ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           stall, flush, id_cond,
    input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, flags_nzcv, cond_taken
  );

  modport slave (
    input  ex_valid, ex_result, ex_negative, ex_zero, ex_overflow, ex_carry_out,
           ex_set_flags, ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           stall, flush, id_cond,
    output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, flags_nzcv, cond_taken
  );
endinterface

// File: rtl/cond_evaluator.sv
// Combinational LEGv8 B.cond evaluation; shared with the branch unit.
module cond_evaluator
  import pipe_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);
  always_comb begin
    taken = 1'b1;
    unique case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_HS: taken = flags.c;
      COND_LO: taken = !flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = !flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = !flags.v;
      COND_HI: taken = flags.c & !flags.z;
      COND_LS: taken = !(flags.c & !flags.z);
      COND_GE: taken = (flags.n == flags.v);
      COND_LT: taken = (flags.n != flags.v);
      COND_GT: taken = !flags.z & (flags.n == flags.v);
      COND_LE: taken = !(!flags.z & (flags.n == flags.v));
      COND_AL, COND_NV: taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/ex_mem_flags_stage.sv
// EX/MEM pipeline register plus the architectural NZCV register, with an EX-stage
// flag bypass feeding B.cond resolution in ID.
module ex_mem_flags_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  ex_mem_flags_stage_if.slave bus
);
  logic                valid_q;
  logic [WIDTH-1:0]    result_q;
  logic [WIDTH-1:0]    store_data_q;
  logic [REG_BITS-1:0] rd_q;
  logic                reg_write_q;
  logic                mem_read_q;
  logic                mem_write_q;
  nzcv_t               flags_q;

  nzcv_t ex_flags;
  nzcv_t eff_flags;
  logic  bypass;
  logic  commit;

  assign ex_flags = make_nzcv(bus.ex_negative, bus.ex_zero, bus.ex_carry_out, bus.ex_overflow);

  // Bypass ignores stall: a stalled setter is still the youngest flag producer.
  assign bypass    = bus.ex_valid & bus.ex_set_flags & !bus.flush;
  assign commit    = bypass & !bus.stall;
  assign eff_flags = bypass ? ex_flags : flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      flags_q      <= '0;
    end else begin
      if (bus.flush) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end else if (!bus.stall) begin
        valid_q      <= bus.ex_valid;
        result_q     <= bus.ex_result;
        store_data_q <= bus.ex_store_data;
        rd_q         <= bus.ex_rd;
        reg_write_q  <= bus.ex_reg_write & bus.ex_valid;
        mem_read_q   <= bus.ex_mem_read  & bus.ex_valid;
        mem_write_q  <= bus.ex_mem_write & bus.ex_valid;
      end
      if (commit) flags_q <= ex_flags;
    end
  end

  cond_evaluator u_cond (
    .flags (eff_flags),
    .cond  (cond_e'(bus.id_cond)),
    .taken (bus.cond_taken)
  );

  assign bus.mem_valid      = valid_q;
  assign bus.mem_result     = result_q;
  assign bus.mem_store_data = store_data_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_reg_write  = reg_write_q;
  assign bus.mem_mem_read   = mem_read_q;
  assign bus.mem_mem_write  = mem_write_q;
  assign bus.flags_nzcv     = flags_q;
endmodule

// File: tb/tb_ex_mem_flags_stage.sv
// Directed-vector scoreboard bench for ex_mem_flags_stage.
module tb_ex_mem_flags_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ex_mem_flags_stage_if #(.WIDTH(64), .REG_BITS(5)) bus ();

  ex_mem_flags_stage #(.WIDTH(64), .REG_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    string nm;
    logic  ct;
  } comb_exp_t;

  typedef struct {
    int          due;
    string       nm;
    logic        pl;
    logic        mv;
    logic [63:0] res;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  nzcv;
  } reg_exp_t;

  comb_exp_t cq[$];
  reg_exp_t  rq[$];
  comb_exp_t cur_c;
  reg_exp_t  cur_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the scoreboard says is due at this cycle.
  always @(negedge clk) begin
    if (cq.size() != 0 && cq[0].due == cyc) begin
      cur_c = cq.pop_front();
      chk({cur_c.nm, ".cond_taken"}, {63'd0, bus.cond_taken}, {63'd0, cur_c.ct});
    end
    if (rq.size() != 0 && rq[0].due == cyc) begin
      cur_r = rq.pop_front();
      chk({cur_r.nm, ".mem_valid"}, {63'd0, bus.mem_valid}, {63'd0, cur_r.mv});
      chk({cur_r.nm, ".mem_reg_write"}, {63'd0, bus.mem_reg_write}, {63'd0, cur_r.rw});
      chk({cur_r.nm, ".mem_mem_read"}, {63'd0, bus.mem_mem_read}, {63'd0, cur_r.mr});
      chk({cur_r.nm, ".mem_mem_write"}, {63'd0, bus.mem_mem_write}, {63'd0, cur_r.mw});
      chk({cur_r.nm, ".flags_nzcv"}, {60'd0, bus.flags_nzcv}, {60'd0, cur_r.nzcv});
      if (cur_r.pl) begin
        chk({cur_r.nm, ".mem_result"}, bus.mem_result, cur_r.res);
        chk({cur_r.nm, ".mem_store_data"}, bus.mem_store_data, cur_r.sd);
        chk({cur_r.nm, ".mem_rd"}, {59'd0, bus.mem_rd}, {59'd0, cur_r.rd});
      end
    end
  end

  // One cycle of stimulus; f is {N,Z,C,V}. Expectations: ct this cycle, e_* after the edge.
  task automatic vec(input string nm, input logic v, input logic [63:0] res,
                     input logic [3:0] f, input logic sf, input logic [63:0] sd,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                     input logic st, input logic fl, input logic rs, input logic [3:0] cond,
                     input logic ct, input logic pl, input logic e_mv,
                     input logic [63:0] e_res, input logic [63:0] e_sd, input logic [4:0] e_rd,
                     input logic e_rw, input logic e_mr, input logic e_mw,
                     input logic [3:0] e_nzcv);
    comb_exp_t c;
    reg_exp_t  r;
    @(posedge clk);
    #1;
    bus.ex_valid      = v;
    bus.ex_result     = res;
    bus.ex_negative   = f[3];
    bus.ex_zero       = f[2];
    bus.ex_carry_out  = f[1];
    bus.ex_overflow   = f[0];
    bus.ex_set_flags  = sf;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    bus.ex_reg_write  = rw;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.stall         = st;
    bus.flush         = fl;
    bus.id_cond       = cond;
    reset             = rs;
    c.due = cyc;     c.nm = nm; c.ct = ct;
    cq.push_back(c);
    r.due = cyc + 1; r.nm = nm; r.pl = pl; r.mv = e_mv; r.res = e_res; r.sd = e_sd;
    r.rd = e_rd; r.rw = e_rw; r.mr = e_mr; r.mw = e_mw; r.nzcv = e_nzcv;
    rq.push_back(r);
  endtask

  task automatic bubble(input string nm, input logic [3:0] cond, input logic ct,
                        input logic [3:0] e_nzcv);
    vec(nm, 0, 64'd0, 4'b0000, 0, 64'd0, 5'd0, 0, 0, 0, 0, 0, 0, cond,
        ct, 0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 0, e_nzcv);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG2 = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    bus.ex_valid = 1; bus.ex_result = ONES; bus.ex_negative = 1; bus.ex_zero = 1;
    bus.ex_carry_out = 1; bus.ex_overflow = 1; bus.ex_set_flags = 1; bus.ex_store_data = ONES;
    bus.ex_rd = 5'd31; bus.ex_reg_write = 1; bus.ex_mem_read = 1; bus.ex_mem_write = 1;
    bus.stall = 1; bus.flush = 1; bus.id_cond = 4'hE;

    //  name          v  res      f        sf sd      rd  rw mr mw st fl rs cond   ct pl mv res      sd     rd  rw mr mw nzcv
    vec("rst_al",     1, ONES,    4'b1111, 1, ONES,   31, 1, 1, 1, 1, 1, 1, 4'hE,  1, 1, 0, 64'd0,   64'd0, 0,  0, 0, 0, 4'b0000);
    vec("rst_eq",     1, ONES,    4'b1111, 1, ONES,   31, 1, 1, 1, 1, 1, 1, 4'h0,  0, 1, 0, 64'd0,   64'd0, 0,  0, 0, 0, 4'b0000);
    vec("subs_eq",    1, 64'd0,   4'b0110, 1, 64'd0,  2,  1, 0, 0, 0, 0, 0, 4'h0,  1, 1, 1, 64'd0,   64'd0, 2,  1, 0, 0, 4'b0110);
    vec("add_nf",     1, 64'h1234,4'b1001, 0, 64'h55, 3,  1, 0, 0, 0, 0, 0, 4'h1,  0, 1, 1, 64'h1234,64'h55,3,  1, 0, 0, 4'b0110);
    vec("stall1",     1, NEG2,    4'b1000, 1, 64'd0,  4,  1, 0, 0, 1, 0, 0, 4'h4,  1, 1, 1, 64'h1234,64'h55,3,  1, 0, 0, 4'b0110);
    vec("stall2",     1, NEG2,    4'b1000, 1, 64'd0,  4,  1, 0, 0, 1, 0, 0, 4'h4,  1, 1, 1, 64'h1234,64'h55,3,  1, 0, 0, 4'b0110);
    vec("unstall",    1, NEG2,    4'b1000, 1, 64'd0,  4,  1, 0, 0, 0, 0, 0, 4'h4,  1, 1, 1, NEG2,    64'd0, 4,  1, 0, 0, 4'b1000);
    vec("flush_st",   1, 64'h100, 4'b0100, 1, 64'hABCD,0, 0, 0, 1, 1, 1, 0, 4'h0,  0, 0, 0, 64'd0,   64'd0, 0,  0, 0, 0, 4'b1000);
    vec("bub_ctl_ge", 0, 64'd7,   4'b0000, 1, 64'd0,  9,  1, 1, 1, 0, 0, 0, 4'hA,  0, 0, 0, 64'd0,   64'd0, 0,  0, 0, 0, 4'b1000);
    bubble("n1v0_lt", 4'hB, 1, 4'b1000);
    bubble("n1v0_gt", 4'hC, 0, 4'b1000);
    bubble("n1v0_le", 4'hD, 1, 4'b1000);
    vec("ldr_set",    1, 64'd5,   4'b1001, 1, 64'h77, 7,  1, 1, 0, 0, 0, 0, 4'hA,  1, 1, 1, 64'd5,   64'h77,7,  1, 1, 0, 4'b1001);
    bubble("n1v1_ge", 4'hA, 1, 4'b1001);
    bubble("n1v1_gt", 4'hC, 1, 4'b1001);
    bubble("n1v1_hi", 4'h8, 0, 4'b1001);
    bubble("nv_always", 4'hF, 1, 4'b1001);
    vec("b2b_1",      1, 64'd9,   4'b0010, 1, 64'd0,  1,  1, 0, 0, 0, 0, 0, 4'h2,  1, 1, 1, 64'd9,   64'd0, 1,  1, 0, 0, 4'b0010);
    vec("b2b_2",      1, 64'd0,   4'b0100, 1, 64'd0,  1,  1, 0, 0, 0, 0, 0, 4'h2,  0, 1, 1, 64'd0,   64'd0, 1,  1, 0, 0, 4'b0100);
    bubble("b2b_eq", 4'h0, 1, 4'b0100);
    vec("rst_stall",  1, ONES,    4'b1111, 1, ONES,   5,  1, 0, 1, 1, 0, 1, 4'h6,  1, 1, 0, 64'd0,   64'd0, 0,  0, 0, 0, 4'b0000);
    bubble("post_rst_ls", 4'h9, 1, 4'b0000);

    for (int i = 0; i < 6 && (cq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    #1;
    if (cq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", cq.size() + rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
